instr_mem_loader: RTL and testbench



---
 rtl/instr_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: length header, little-endian payload, one write per word.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module instr_mem_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] ONE = LW'(1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_COLLECT, S_WRITE, S_DONE, S_ERR, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_COLLECT, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_word_idx;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_asm;
    logic          r_in_ready;
    logic          r_wr_en;
    logic [31:0]   r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_error;
    logic          w_xfer;
    logic          w_hdr_bad;
    logic          w_last;
    logic          w_restart;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    assign w_xfer    = in_valid && r_in_ready;
    assign w_hdr_bad = (in_data == 8'd0) || (32'(in_data) > DEPTH);
    assign w_last    = ((r_word_idx + ONE) == r_len);
    assign w_restart = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) w_next = w_hdr_bad ? S_ERR : S_COLLECT;
            end
            S_COLLECT: begin
                if (w_xfer && r_byte_idx == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                w_next = w_last ? S_CHK : S_COLLECT;
`else
                w_next = w_last ? S_DONE : S_COLLECT;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are true flops aligned with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
`ifdef LOADER_CHECKSUM_EN
            r_in_ready <= (w_next == S_LEN) || (w_next == S_COLLECT) || (w_next == S_CHK);
`else
            r_in_ready <= (w_next == S_LEN) || (w_next == S_COLLECT);
`endif
            r_wr_en    <= (w_next == S_WRITE);
            r_cpu_hold <= (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);
            r_error    <= (w_next == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            if (r_state == S_LEN && w_xfer && !w_hdr_bad) begin
                r_len      <= LW'(in_data);
                r_word_idx <= '0;
                r_byte_idx <= '0;
            end
            if (r_state == S_COLLECT && w_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_asm[7:0]   <= in_data;
                    2'd1: r_asm[15:8]  <= in_data;
                    2'd2: r_asm[23:16] <= in_data;
                    default: begin
                        // Output word/address are captured only here so they hold between writes.
                        r_wr_data <= {in_data, r_asm};
                        r_wr_addr <= BASE_ADDR + (32'(r_word_idx) << 2);
                    end
                endcase
            end
            if (r_state == S_WRITE) begin
                r_word_idx <= r_word_idx + ONE;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_restart) begin
            r_csum <= '0;
        end else if (r_state == S_COLLECT && w_xfer) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes queued at stimulus time, compared against captured writes.
`timescale 1ns/1ps
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    localparam logic [31:0] BASE = 32'h0000_0000;

    instr_mem_loader #(.DEPTH(64), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int multi_cnt = 0;
    logic prev_wr_en = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];
    logic [7:0]  pay_q[$];

    always @(negedge clk) begin
        if (rst_n && wr_en) act_q.push_back({wr_addr, wr_data});
        if (rst_n && wr_en && prev_wr_en) multi_cnt <= multi_cnt + 1;
        prev_wr_en <= rst_n && wr_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout in_ready=%b required=1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_load(input logic [7:0] hdr, input bit gaps, input bit bad_csum, input int start_at);
        logic [7:0] cs = 8'h00;
        int n = 0;
        if (hdr != 8'd0 && hdr <= 8'd64) begin
            for (int w = 0; w < int'(hdr); w++)
                exp_q.push_back({BASE + 32'(4 * w),
                                 pay_q[4*w+3], pay_q[4*w+2], pay_q[4*w+1], pay_q[4*w]});
        end
        pulse_start();
        send_byte(hdr, gaps);
        for (int i = 0; i < pay_q.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(pay_q[i], gaps);
            cs = cs ^ pay_q[i];
        end
`ifdef LOADER_CHECKSUM_EN
        if (hdr != 8'd0 && hdr <= 8'd64) send_byte(bad_csum ? (cs ^ 8'h5A) : cs, gaps);
`else
        if (bad_csum) cs = 8'h00;
`endif
        while (!(done || error) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL load_end_timeout done=%b error=%b required=one_set", done, error);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, wr_en, cpu_hold, done, error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_status {rdy,wen,hold,done,err} got=%b exp=00100",
                     {in_ready, wr_en, cpu_hold, done, error});
        end
        checks++;
        if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h exp=0/0", wr_addr, wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset rdy=%b hold=%b exp=0/1", in_ready, cpu_hold);
        end
    endtask

    task automatic test_basic(input bit bad_csum);
        pay_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(8'h02, 1'b0, bad_csum, -1);
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_write_count got=%0d exp=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_write%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
        act_q.delete(); exp_q.delete();
        checks++;
        if ({done, error, cpu_hold, in_ready} !== (bad_csum ? 4'b0110 : 4'b1000)) begin
            errors++;
            $display("FAIL basic_status {done,err,hold,rdy} got=%b exp=%b",
                     {done, error, cpu_hold, in_ready}, bad_csum ? 4'b0110 : 4'b1000);
        end
        checks++;
        if (multi_cnt != 0) begin
            errors++;
            $display("FAIL basic_wr_en_width got=%0d long pulses exp=0", multi_cnt);
        end
    endtask

    task automatic test_bad_header();
        pay_q.delete();
        run_load(8'h00, 1'b0, 1'b0, -1);
        checks++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            errors++;
            $display("FAIL hdr0_status {done,err,hold} got=%b exp=011", {done, error, cpu_hold});
        end
        run_load(8'h41, 1'b0, 1'b0, -1);
        checks++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            errors++;
            $display("FAIL hdr65_status {done,err,hold} got=%b exp=011", {done, error, cpu_hold});
        end
        checks++;
        if (act_q.size() != 0) begin
            errors++;
            $display("FAIL bad_hdr_writes got=%0d exp=0", act_q.size());
        end
        act_q.delete();
        pay_q = '{8'hB7, 8'h02, 8'h00, 8'h00};
        run_load(8'h01, 1'b0, 1'b0, -1);
        checks++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL recover_status {done,err,hold} got=%b exp=100", {done, error, cpu_hold});
        end
        checks++;
        if (act_q.size() != 1 || exp_q.size() != 1 || act_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL recover_write got_n=%0d exp_n=%0d", act_q.size(), exp_q.size());
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_full();
        pay_q.delete();
        for (int i = 0; i < 256; i++) pay_q.push_back(8'($urandom));
        run_load(8'h40, 1'b1, 1'b0, -1);
        checks++;
        if (act_q.size() != 64) begin
            errors++;
            $display("FAIL full_write_count got=%0d exp=64", act_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_write%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (act_q.size() == 64 && act_q[63][63:32] !== 32'h0000_00FC) begin
            errors++;
            $display("FAIL full_last_addr got=%h exp=000000fc", act_q[63][63:32]);
        end
        act_q.delete(); exp_q.delete();
        checks++;
        if ({done, cpu_hold, multi_cnt != 0} !== 3'b100) begin
            errors++;
            $display("FAIL full_status {done,hold,longpulse} got=%b exp=100", {done, cpu_hold, multi_cnt != 0});
        end
    endtask

    task automatic test_reset_mid();
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back({BASE, 32'h4433_2211});
        pulse_start();
        send_byte(8'h04, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pay_q[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, wr_en, cpu_hold, done, error} !== 5'b00100 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs status=%b addr=%h data=%h exp=00100/0/0",
                     {in_ready, wr_en, cpu_hold, done, error}, wr_addr, wr_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (act_q.size() != 1 || act_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL midreset_writes got_n=%0d exp_n=1", act_q.size());
        end
        act_q.delete(); exp_q.delete();
        pay_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(8'h01, 1'b0, 1'b0, -1);
        checks++;
        if (done !== 1'b1 || act_q.size() != 1 || act_q[0] !== {BASE, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL midreset_reload done=%b n=%0d exp=1/1", done, act_q.size());
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_start_ignored();
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(8'h02, 1'b0, 1'b0, 2);
        checks++;
        if (done !== 1'b1 || act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL start_in_collect done=%b n=%0d exp=1/2", done, act_q.size());
        end
        act_q.delete(); exp_q.delete();
        pulse_start();
        checks++;
        if ({done, cpu_hold, in_ready} !== 3'b011) begin
            errors++;
            $display("FAIL start_in_done {done,hold,rdy} got=%b exp=011", {done, cpu_hold, in_ready});
        end
        pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load(8'h01, 1'b0, 1'b0, -1);
        checks++;
        if (done !== 1'b1 || act_q.size() != 1 || act_q[0] !== {BASE, 32'hD4C3_B2A1}) begin
            errors++;
            $display("FAIL start_in_len done=%b n=%0d exp=1/1", done, act_q.size());
        end
        act_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_bad_header();
        test_full();
        test_reset_mid();
        test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
        test_basic(1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
